// File: rtl/fifo_pkg.sv
// Shared types and default geometry for the delay buffer and its drain controller.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_BITS  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_if.sv
// Host and delay-buffer signals of the drain controller, grouped as one bundle.
interface fifo_drain_if
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BITS  = FIFO_BITS
);
  localparam int AW = $clog2(DEPTH);

  logic            start;
  logic            recirc;
  logic [BITS-1:0] fill_d;
  logic [BITS-1:0] fifo_q;
  logic            fifo_en;
  logic [BITS-1:0] fifo_d;
  logic [AW-1:0]   rd_addr;
  logic [BITS-1:0] rd_data;
  logic            busy;
  logic            done;

  modport master (
    output start, recirc, fill_d, fifo_q, rd_addr,
    input  fifo_en, fifo_d, rd_data, busy, done
  );

  modport slave (
    input  start, recirc, fill_d, fifo_q, rd_addr,
    output fifo_en, fifo_d, rd_data, busy, done
  );
endinterface

// File: rtl/drain_capture_ram.sv
// Capture file: one write port, one registered read port, async clear.
module drain_capture_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BITS  = FIFO_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [BITS-1:0] rd_data_q;
  logic [BITS-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Read from the pre-write array so a same-edge write returns the old word;
  // indices with no entry (non-power-of-2 DEPTH) fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rd_data_d = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/fifo.sv
// Shift-register delay buffer: d enters at entry 0, q is the oldest entry.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BITS  = FIFO_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = d;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/fifo_drain.sv
// Drains the delay buffer into the capture file, recirculating or refilling it.
//   state | meaning
//   IDLE  | waiting for start
//   DRAIN | fifo_en high, one capture per cycle, DEPTH cycles
//   DONE  | one-cycle completion pulse
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BITS  = FIFO_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_drain_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            cap_we;
  logic [BITS-1:0] rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          mode_d  = bus.recirc;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign cap_we = (state_q == S_DRAIN);

  drain_capture_ram #(
    .DEPTH (DEPTH),
    .BITS  (BITS),
    .AW    (AW)
  ) u_cap (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cap_we),
    .waddr (cnt_q),
    .wdata (bus.fifo_q),
    .raddr (bus.rd_addr),
    .rdata (rd_data)
  );

  assign bus.fifo_en = (state_q == S_DRAIN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.fifo_d  = mode_q ? bus.fifo_q : bus.fill_d;
  assign bus.rd_data = rd_data;

endmodule
